// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment display scan engine
// and the tick generator it reuses.
package disp_pkg;

    localparam int DIG_W_DEF = 4;
    localparam int AN_MAX    = 32;

    // Wide enough for any supported digit count; users slice the low N bits.
    localparam logic [AN_MAX-1:0] AN_OFF = '1;

    typedef logic [DIG_W_DEF-1:0] digit_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: emits a one-cycle pulse every DIV clocks, the first
// one in the DIV-th cycle after reset release.
module tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic scan_tick
);

    localparam int              CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign scan_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/display_scan_mux.sv
// Seven-segment scan engine: walks the digit index once per prescaler tick,
// inserts one dead cycle between digits and shows a frame snapshot taken at idx 0.
module display_scan_mux
    import disp_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int DIG_W    = DIG_W_DEF,
    parameter int DIV      = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_DIGITS*DIG_W-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]         dp_in,
    input  logic [N_DIGITS-1:0]         en_mask,
    input  logic                        lz_blank,
    output logic [N_DIGITS-1:0]         an,
    output logic [DIG_W-1:0]            digit,
    output logic                        dp,
    output logic [$clog2(N_DIGITS)-1:0] idx,
    output logic                        scan_tick
);

    localparam int                     IDX_W    = $clog2(N_DIGITS);
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0]    AN_BLANK = AN_OFF[N_DIGITS-1:0];

    logic tick;

    logic                      load_q, load_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N_DIGITS-1:0]       an_q, an_d;
    logic [DIG_W-1:0]          digit_q, digit_d;
    logic                      dp_q, dp_d;
    logic [N_DIGITS*DIG_W-1:0] fr_digits_q, fr_digits_d;
    logic [N_DIGITS-1:0]       fr_dp_q, fr_dp_d;
    logic [N_DIGITS-1:0]       fr_en_q, fr_en_d;
    logic                      fr_lz_q, fr_lz_d;

    logic [N_DIGITS-1:0]       blank;
    logic                      zero_run;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .scan_tick (tick)
    );

    // Walk down from the top digit; zero_run stays set while every digit seen
    // so far is zero, which is exactly the leading-zero region.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (fr_digits_q[i*DIG_W +: DIG_W] == '0);
            blank[i] = !fr_en_q[i] || (fr_lz_q && zero_run && (i != 0));
        end
    end

    // Tick cycle advances the index and opens the dead cycle; the cycle after
    // (load_q) lights the new slot from the frame snapshot.
    always_comb begin
        idx_d       = idx_q;
        an_d        = an_q;
        digit_d     = digit_q;
        dp_d        = dp_q;
        fr_digits_d = fr_digits_q;
        fr_dp_d     = fr_dp_q;
        fr_en_d     = fr_en_q;
        fr_lz_d     = fr_lz_q;
        load_d      = tick;

        if (tick) begin
            an_d = AN_BLANK;
            if (idx_q == IDX_LAST) begin
                idx_d       = '0;
                fr_digits_d = digits_in;
                fr_dp_d     = dp_in;
                fr_en_d     = en_mask;
                fr_lz_d     = lz_blank;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (load_q) begin
            if (blank[idx_q]) begin
                an_d    = AN_BLANK;
                digit_d = '0;
                dp_d    = 1'b0;
            end else begin
                an_d    = ~(N_DIGITS'(1) << idx_q);
                digit_d = fr_digits_q[int'(idx_q)*DIG_W +: DIG_W];
                dp_d    = fr_dp_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_q      <= 1'b0;
            idx_q       <= IDX_LAST;
            an_q        <= AN_BLANK;
            digit_q     <= '0;
            dp_q        <= 1'b0;
            fr_digits_q <= '0;
            fr_dp_q     <= '0;
            fr_en_q     <= '0;
            fr_lz_q     <= 1'b0;
        end else begin
            load_q      <= load_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            digit_q     <= digit_d;
            dp_q        <= dp_d;
            fr_digits_q <= fr_digits_d;
            fr_dp_q     <= fr_dp_d;
            fr_en_q     <= fr_en_d;
            fr_lz_q     <= fr_lz_d;
        end
    end

    assign an        = an_q;
    assign digit     = digit_q;
    assign dp        = dp_q;
    assign idx       = idx_q;
    assign scan_tick = tick;

endmodule
